header_stripper: RTL and testbench
==================================

// Module: header_stripper
// PURPOSE
//  Receive-side counterpart of the header insertion stage: removes a fixed
//  HEADER_SIZE-bit header from the front of every Avalon-ST packet.
//  Captures the header in a register and forwards only the payload, with
//  sop re-generated on the first payload beat. Sits between the link
//  interface and the AES datapath.
// PARAMETERS
//  DATA_WIDTH   128  Avalon-ST data width in bits.
//  HEADER_SIZE  256  Header width in bits; integer multiple of DATA_WIDTH and >= DATA_WIDTH.
//  CNT_WIDTH    16   Width of drop_cnt.
// PORTS
//  clk              in   1            Clock.
//  rst_n            in   1            Reset: asynchronous, active-low.
//  data_in          slave   avalon_st_if (DATA_WIDTH)  Packet input; header first.
//  data_out         master  avalon_st_if (DATA_WIDTH)  Payload output.
//  expected_header  in   HEADER_SIZE  Reference header; used only with HDR_CHECK_EN.
//  header_out       out  HEADER_SIZE  Last captured header.
//  header_valid     out  1            1-cycle pulse when header_out updates.
//  hdr_err          out  1            1-cycle pulse when a packet is dropped.
//  drop_cnt         out  CNT_WIDTH    Dropped-packet count; saturates at all-ones.
// BEHAVIOUR
//  - NBEATS = HEADER_SIZE/DATA_WIDTH. First header beat carries header bits [HEADER_SIZE-1 -: DATA_WIDTH] (MSB first).
//  - Reset values: data_out.valid/sop/eop = 0, data_out.empty = 0, header_out = 0,
//    header_valid = 0, hdr_err = 0, drop_cnt = 0. State = IDLE_ST, beat_cntr = 0.
//  - Transfer means valid & ready in the same cycle. All state changes occur on transfers only.
//  - IDLE_ST: data_in.ready = 1, data_out.valid = 0.
//    Beat with sop: store it as header beat 0. If NBEATS == 1, go to CHECK; else go to HDR_ST with beat_cntr = 1.
//    Beat without sop: discarded silently, stay in IDLE_ST.
//  - HDR_ST: data_in.ready = 1, data_out.valid = 0. Each beat is stored at slot beat_cntr and beat_cntr increments.
//    On the last beat (beat_cntr == NBEATS-1), go to CHECK.
//  - CHECK (combinational on the last header beat): load header_out and pulse header_valid the next cycle.
//    If the last header beat has eop (header-only packet) -> drop: pulse hdr_err, increment drop_cnt, go to IDLE_ST.
//    Otherwise go to DATA_ST with first_flag = 1.
//  - eop on any header beat before the last one: same as a header-only packet (drop, hdr_err, drop_cnt++, IDLE_ST).
//  - DATA_ST: combinational pass-through, zero latency.
//    data_out.valid = data_in.valid; data_in.ready = data_out.ready.
//    data_out.data, eop and empty pass through unchanged.
//    data_out.sop = first_flag; first_flag clears on the first payload transfer.
//    An input sop seen in DATA_ST is ignored (not forwarded).
//    Transfer with eop -> IDLE_ST, beat_cntr = 0.
//  - DROP_ST (HDR_CHECK_EN only): data_in.ready = 1, data_out.valid = 0. Consume beats until an eop transfer, then IDLE_ST.
//  - Output data_out.empty is 0 unless data_out.eop is set.
//  - Back-to-back packets: the cycle after an eop transfer, IDLE_ST accepts a new sop with no bubble.
//  - Reset mid-packet: return to IDLE_ST; the remainder of the packet is discarded as non-sop beats.
//  - drop_cnt saturates at 2^CNT_WIDTH-1 and does not wrap.
// CONFIGURATION
//  HDR_CHECK_EN defined:
//    - In CHECK, compare the full assembled header with expected_header.
//    - Mismatch (and no eop): pulse hdr_err, drop_cnt++, go to DROP_ST. No payload beat is forwarded.
//    - header_out/header_valid still update with the received header.
//  HDR_CHECK_EN undefined:
//    - expected_header is unused; every header is accepted.
//    - DROP_ST does not exist; hdr_err fires only for header-only or short packets.
// TESTING (DATA_WIDTH=128, HEADER_SIZE=256 unless stated)
//  1. Packet of 2 header beats (H1,H0) + 3 payload beats (P0..P2, eop on P2, empty=4), data_out.ready=1
//     -> out: P0(sop) P1 P2(eop, empty=4); header_out = {H1,H0}; single header_valid pulse.
//  2. Same packet with data_out.ready toggling 1/0 every cycle
//     -> payload order and sop/eop preserved; header beats accepted while ready=0.
//  3. eop on header beat 1 -> no output beats; hdr_err pulse; drop_cnt=1; next packet passes cleanly.
//  4. Two back-to-back packets with no idle cycles -> both forwarded, each with exactly one sop; second header captured.
//  5. HDR_CHECK_EN, expected_header=256'hA5.., header mismatching in bit 0
//     -> payload dropped; hdr_err pulse; drop_cnt++; following matching packet forwarded.
//  6. Assert rst_n low during payload beat 1, then continue driving input
//     -> outputs at reset values; stray beats discarded; next sop packet is correct.

Source files
------------

// File: rtl/header_stripper.sv
// Removes a fixed HEADER_SIZE-bit header from the front of each Avalon-ST packet and
// forwards the payload with sop regenerated. Define HDR_CHECK_EN to drop packets whose header mismatches.
// state   | meaning
// IDLE_ST | waiting for sop; non-sop beats discarded
// HDR_ST  | collecting header beats 1..NBEATS-1
// DATA_ST | payload pass-through
// DROP_ST | (HDR_CHECK_EN) consuming rest of a rejected packet
module header_stripper #(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256,
    parameter int CNT_WIDTH   = 16,
    parameter int EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_in_valid_i,
    output logic                   data_in_ready_o,
    input  logic [DATA_WIDTH-1:0]  data_in_data_i,
    input  logic                   data_in_sop_i,
    input  logic                   data_in_eop_i,
    input  logic [EMPTY_WIDTH-1:0] data_in_empty_i,
    output logic                   data_out_valid_o,
    input  logic                   data_out_ready_i,
    output logic [DATA_WIDTH-1:0]  data_out_data_o,
    output logic                   data_out_sop_o,
    output logic                   data_out_eop_o,
    output logic [EMPTY_WIDTH-1:0] data_out_empty_o,
    input  logic [HEADER_SIZE-1:0] expected_header_i,
    output logic [HEADER_SIZE-1:0] header_out_o,
    output logic                   header_valid_o,
    output logic                   hdr_err_o,
    output logic [CNT_WIDTH-1:0]   drop_cnt_o
);
    localparam int NBEATS = HEADER_SIZE / DATA_WIDTH;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

`ifdef HDR_CHECK_EN
    typedef enum logic [1:0] {IDLE_ST, HDR_ST, DATA_ST, DROP_ST} state_t;
    logic hdr_mismatch;
`else
    typedef enum logic [1:0] {IDLE_ST, HDR_ST, DATA_ST} state_t;
    logic unused_expected;
    assign unused_expected = ^expected_header_i;
`endif

    state_t                 state_q, state_d;
    logic [BW-1:0]          beat_cntr_q, beat_cntr_d;
    logic [HEADER_SIZE-1:0] hdr_buf_q, hdr_buf_d;
    logic [HEADER_SIZE-1:0] header_q, header_d;
    logic                   hv_q, hv_d;
    logic                   err_q, err_d;
    logic                   first_q, first_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [HEADER_SIZE-1:0] hdr_asm;
    logic                   hdr_take, last_beat, drop;
    int                     slot;

    always_comb begin
        state_d          = state_q;
        beat_cntr_d      = beat_cntr_q;
        hdr_buf_d        = hdr_buf_q;
        header_d         = header_q;
        hv_d             = 1'b0;
        err_d            = 1'b0;
        first_d          = first_q;
        drop             = 1'b0;
        data_in_ready_o  = 1'b1;
        data_out_valid_o = 1'b0;
        data_out_sop_o   = 1'b0;
        data_out_eop_o   = 1'b0;
        slot             = int'(beat_cntr_q);
        last_beat        = (beat_cntr_q == BW'(NBEATS - 1));
        // The last header slot always occupies the low DATA_WIDTH bits.
        hdr_asm                   = hdr_buf_q;
        hdr_asm[DATA_WIDTH-1:0]   = data_in_data_i;
`ifdef HDR_CHECK_EN
        hdr_mismatch = (hdr_asm != expected_header_i);
`endif
        hdr_take = data_in_valid_i &&
                   ((state_q == IDLE_ST && data_in_sop_i) || state_q == HDR_ST);

        if (hdr_take) begin
            hdr_buf_d[HEADER_SIZE-1 - slot*DATA_WIDTH -: DATA_WIDTH] = data_in_data_i;
            if (last_beat) begin
                header_d    = hdr_asm;
                hv_d        = 1'b1;
                beat_cntr_d = '0;
                if (data_in_eop_i) begin
                    drop    = 1'b1;
                    state_d = IDLE_ST;
                end
`ifdef HDR_CHECK_EN
                else if (hdr_mismatch) begin
                    drop    = 1'b1;
                    state_d = DROP_ST;
                end
`endif
                else begin
                    state_d = DATA_ST;
                    first_d = 1'b1;
                end
            end else if (data_in_eop_i) begin
                drop        = 1'b1;
                state_d     = IDLE_ST;
                beat_cntr_d = '0;
            end else begin
                state_d     = HDR_ST;
                beat_cntr_d = beat_cntr_q + BW'(1);
            end
        end

        if (state_q == DATA_ST) begin
            data_out_valid_o = data_in_valid_i;
            data_in_ready_o  = data_out_ready_i;
            data_out_sop_o   = first_q;
            data_out_eop_o   = data_in_eop_i;
            if (data_in_valid_i && data_out_ready_i) begin
                first_d = 1'b0;
                if (data_in_eop_i) begin
                    state_d     = IDLE_ST;
                    beat_cntr_d = '0;
                end
            end
        end
`ifdef HDR_CHECK_EN
        if (state_q == DROP_ST && data_in_valid_i && data_in_eop_i) begin
            state_d = IDLE_ST;
        end
`endif
        err_d      = drop;
        drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + CNT_WIDTH'(1) : drop_cnt_q;
    end

    assign data_out_data_o  = data_in_data_i;
    assign data_out_empty_o = data_out_eop_o ? data_in_empty_i : '0;
    assign header_out_o     = header_q;
    assign header_valid_o   = hv_q;
    assign hdr_err_o        = err_q;
    assign drop_cnt_o       = drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_ST;
            beat_cntr_q <= '0;
            hdr_buf_q   <= '0;
            header_q    <= '0;
            hv_q        <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cntr_q <= beat_cntr_d;
            hdr_buf_q   <= hdr_buf_d;
            header_q    <= header_d;
            hv_q        <= hv_d;
            err_q       <= err_d;
            first_q     <= first_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_header_stripper.sv
// Directed bench for header_stripper: scoreboard of expected payload beats plus
// register/pulse checks for header capture, drops, saturation and reset.
module tb_header_stripper;
    localparam int DW = 128;
    localparam int HS = 256;
    localparam int CW = 4;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [EW-1:0] in_empty = '0;
    logic          in_ready;
    logic          out_valid, out_sop, out_eop;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [EW-1:0] out_empty;
    logic [HS-1:0] exp_hdr = '0;
    logic [HS-1:0] header_out;
    logic          header_valid, hdr_err;
    logic [CW-1:0] drop_cnt;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    beat_t sb[$];
    int    checks = 0, errors = 0;
    int    hv_cnt = 0, err_cnt = 0;
    int    exp_drop = 0;
    bit    tog_en = 1'b0;

    header_stripper #(.DATA_WIDTH(DW), .HEADER_SIZE(HS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in_valid_i(in_valid), .data_in_ready_o(in_ready), .data_in_data_i(in_data),
        .data_in_sop_i(in_sop), .data_in_eop_i(in_eop), .data_in_empty_i(in_empty),
        .data_out_valid_o(out_valid), .data_out_ready_i(out_ready), .data_out_data_o(out_data),
        .data_out_sop_o(out_sop), .data_out_eop_o(out_eop), .data_out_empty_o(out_empty),
        .expected_header_i(exp_hdr), .header_out_o(header_out), .header_valid_o(header_valid),
        .hdr_err_o(hdr_err), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) out_ready = ~out_ready;
        end
    end

    // Output monitor: every accepted output beat must match the scoreboard head.
    always @(negedge clk) begin
        beat_t got, exp;
        if (rst_n) begin
            if (header_valid) hv_cnt++;
            if (hdr_err) err_cnt++;
        end
        if (out_valid && out_ready) begin
            got = '{out_data, out_sop, out_eop, out_empty};
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat got=%h expected=none", got);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                assert (got === exp) else begin
                    errors++;
                    $error("FAIL out_beat got=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [HS-1:0] got, input logic [HS-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] em);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_empty = em;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $error("FAIL send_timeout got=stalled expected=ready");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_hdr(input logic [HS-1:0] h, input bit good);
        if (good) exp_hdr = h;
        send(h[HS-1 -: DW], 1'b1, 1'b0, 4'd9);
        send(h[DW-1:0], 1'b0, 1'b0, 4'd3);
    endtask

    // Payload beat 1 carries a stray sop that must not be forwarded; non-eop empties are nonzero.
    task automatic send_pay(input int np, input logic [EW-1:0] last_empty, input bit fwd);
        logic [DW-1:0] p;
        bit            last;
        for (int i = 0; i < np; i++) begin
            p    = rnd();
            last = (i == np - 1);
            if (fwd) sb.push_back('{p, (i == 0), last, last ? last_empty : 4'd0});
            send(p, (i == 1), last, last ? last_empty : 4'd7);
        end
    endtask

    function automatic logic [HS-1:0] rnd_hdr();
        return {rnd(), rnd()};
    endfunction

    function automatic int sat_inc(input int v);
        return (v == 15) ? 15 : v + 1;
    endfunction

    initial begin
        logic [HS-1:0] h, h2;
        int            hv0, err0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_header_out", header_out, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 1: basic packet, ready held high
        h = rnd_hdr(); hv0 = hv_cnt;
        send_hdr(h, 1'b1);
        send_pay(3, 4'd4, 1'b1);
        idle(2);
        chk("t1_header_out", header_out, h);
        chk("t1_hv_pulses", hv_cnt - hv0, 1);

        // 2: output backpressure toggling; header beats must not wait on data_out ready
        h = rnd_hdr(); exp_hdr = h;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = h[HS-1 -: DW]; in_sop = 1'b1; in_eop = 1'b0;
        @(negedge clk);
        chk("t2_hdr_ready_while_stalled", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0;
        send(h[DW-1:0], 1'b0, 1'b0, 4'd0);
        tog_en = 1'b1;
        send_pay(4, 4'd2, 1'b1);
        tog_en = 1'b0; out_ready = 1'b1;
        idle(2);
        chk("t2_header_out", header_out, h);

        // 3: eop on last header beat -> header-only drop
        h = rnd_hdr(); exp_hdr = h; err0 = err_cnt; hv0 = hv_cnt;
        send(h[HS-1 -: DW], 1'b1, 1'b0, 4'd0);
        send(h[DW-1:0], 1'b0, 1'b1, 4'd0);
        exp_drop = sat_inc(exp_drop);
        idle(2);
        chk("t3_hdr_err_pulses", err_cnt - err0, 1);
        chk("t3_drop_cnt", drop_cnt, exp_drop);
        chk("t3_header_loaded", header_out, h);
        chk("t3_hv_pulses", hv_cnt - hv0, 1);
        // eop on the first header beat -> short packet drop, header not loaded
        err0 = err_cnt; hv0 = hv_cnt;
        send(rnd(), 1'b1, 1'b1, 4'd0);
        exp_drop = sat_inc(exp_drop);
        send(rnd(), 1'b0, 1'b0, 4'd0);
        idle(2);
        chk("t3_short_err", err_cnt - err0, 1);
        chk("t3_short_hv", hv_cnt - hv0, 0);
        chk("t3_short_drop_cnt", drop_cnt, exp_drop);
        h = rnd_hdr();
        send_hdr(h, 1'b1);
        send_pay(2, 4'd1, 1'b1);

        // 4: back-to-back packets, no idle cycles
        h = rnd_hdr(); h2 = rnd_hdr(); hv0 = hv_cnt;
        send_hdr(h, 1'b1);
        send_pay(2, 4'd5, 1'b1);
        send_hdr(h2, 1'b1);
        send_pay(3, 4'd0, 1'b1);
        idle(2);
        chk("t4_header_out", header_out, h2);
        chk("t4_hv_pulses", hv_cnt - hv0, 2);

        // 5: header compare; without the check every header is forwarded
        exp_hdr = {32{8'hA5}};
        h = exp_hdr ^ {{(HS-1){1'b0}}, 1'b1};
        err0 = err_cnt;
`ifdef HDR_CHECK_EN
        send_hdr(h, 1'b0);
        send_pay(3, 4'd6, 1'b0);
        exp_drop = sat_inc(exp_drop);
        idle(2);
        chk("t5_hdr_err", err_cnt - err0, 1);
        chk("t5_drop_cnt", drop_cnt, exp_drop);
        chk("t5_header_out", header_out, h);
        send_hdr({32{8'hA5}}, 1'b1);
        send_pay(2, 4'd6, 1'b1);
`else
        send_hdr(h, 1'b0);
        send_pay(3, 4'd6, 1'b1);
        idle(2);
        chk("t5_no_err", err_cnt - err0, 0);
        chk("t5_drop_cnt", drop_cnt, exp_drop);
        chk("t5_header_out", header_out, h);
`endif

        // drop_cnt saturation
        for (int i = 0; i < 20; i++) begin
            send(rnd(), 1'b1, 1'b1, 4'd0);
            exp_drop = sat_inc(exp_drop);
        end
        idle(2);
        chk("sat_drop_cnt", drop_cnt, exp_drop);

        // 6: reset during payload beat 1
        h = rnd_hdr();
        send_hdr(h, 1'b1);
        begin
            logic [DW-1:0] p0;
            p0 = rnd();
            sb.push_back('{p0, 1'b1, 1'b0, 4'd0});
            send(p0, 1'b0, 1'b0, 4'd0);
        end
        in_valid = 1'b1; in_data = rnd(); in_sop = 1'b0; in_eop = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_header_out", header_out, 0);
        chk("t6_drop_cnt", drop_cnt, 0);
        chk("t6_hdr_err", hdr_err, 0);
        chk("t6_header_valid", header_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        in_valid = 1'b0;
        send(rnd(), 1'b0, 1'b1, 4'd3);
        h = rnd_hdr();
        send_hdr(h, 1'b1);
        send_pay(3, 4'd8, 1'b1);
        idle(3);
        chk("t6_header_after", header_out, h);
        chk("t6_drop_after", drop_cnt, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
